// File: rtl/handshake_rx.sv
// Receive side of the 4-phase req/ack link: synchronises req, captures the bundled
// command, returns ack and issues a one-cycle valid pulse per accepted command.
//
// state      | meaning
// WAIT_IDLE  | ack low; wait for a trustworthy req_s=0 before accepting anything
// IDLE       | ack low, not busy; a high req_s starts a transfer
// CAPTURE    | command just latched, valid pulse and ack visible for one cycle
// ACK_HIGH   | ack held high until req_s falls or the timeout expires
module handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_fpga,
  input  logic              reset,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_dados,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_cmd,
  output logic              o_cmd_valid,
  output logic              o_busy,
  output logic              o_timeout
);

  localparam logic [1:0] S_WAIT_IDLE = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_CAPTURE   = 2'd2;
  localparam logic [1:0] S_ACK_HIGH  = 2'd3;

  localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] CNT_SETTLE = 16'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [1:0]             state;
  logic [15:0]            count;

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_req};
    end
  end

  assign req_s  = sync_q[SYNC_STAGES-1];
  assign o_busy = (state != S_IDLE);

  // After reset the synchroniser holds cleared zeros, not real samples of i_req.
  // WAIT_IDLE lets the counter run up to SYNC_STAGES so a req held high across
  // reset release is not mistaken for a low. After a timeout the counter is
  // already past that point.
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      state       <= S_WAIT_IDLE;
      o_ack       <= 1'b0;
      o_cmd       <= '0;
      o_cmd_valid <= 1'b0;
      o_timeout   <= 1'b0;
      count       <= '0;
    end else begin
      o_cmd_valid <= 1'b0;
      o_timeout   <= 1'b0;
      case (state)
        S_WAIT_IDLE: begin
          if (count < CNT_SETTLE) begin
            count <= count + 16'd1;
          end else if (!req_s) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (req_s) begin
            state       <= S_CAPTURE;
            o_cmd       <= i_dados;
            o_cmd_valid <= 1'b1;
            o_ack       <= 1'b1;
            count       <= '0;
          end
        end
        S_CAPTURE: begin
          count <= count + 16'd1;
          state <= S_ACK_HIGH;
        end
        S_ACK_HIGH: begin
          if (!req_s) begin
            o_ack <= 1'b0;
            state <= S_IDLE;
          end else if (count == CNT_LAST) begin
            o_ack     <= 1'b0;
            o_timeout <= 1'b1;
            state     <= S_WAIT_IDLE;
          end else begin
            count <= count + 16'd1;
          end
        end
        default: begin
          o_ack <= 1'b0;
          state <= S_WAIT_IDLE;
        end
      endcase
    end
  end

endmodule
